encrypt_function_4: RTL and testbench

- Transmit-side counterpart of the function-4 decryptor.
- Accepts a 60-bit plaintext word over a valid/ready handshake and draws an 11-bit key from an internal LFSR.
- Emits a 78-bit frame laid out as {key[10:0], y[60:0], FUNC_ID[5:0]}, where y = {plain,1'b0} + b mod 2^61. Subtracting b from y and taking bits [60:1] recovers the plaintext exactly.
- Sits between the plaintext source and the channel that feeds the function-4 decrypt path.

---
 rtl/encrypt_function_4.sv | 116 +++++++++++
 tb/tb_encrypt_function_4.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/encrypt_function_4.sv
// rtl/encrypt_function_4.sv - function-4 encryptor: LFSR-keyed additive mask over a 60-bit word
module encrypt_function_4 #(
    parameter logic [5:0]  FUNC_ID   = 6'd4,
    parameter logic [10:0] LFSR_SEED = 11'h5A5
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        seed_load,
    input  logic [10:0] seed,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [59:0] data_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [77:0] outEnc,
    output logic [15:0] enc_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q,     state_d;
    logic [10:0] lfsr_q,      lfsr_d;
    logic [59:0] p_q,         p_d;
    logic [10:0] r_q,         r_d;
    logic        out_valid_q, out_valid_d;
    logic [77:0] out_enc_q,   out_enc_d;
    logic [15:0] enc_count_q, enc_count_d;

    logic [10:0] lfsr_next;
    logic [59:0] mask_b;
    logic [60:0] masked_y;

    // x^11 + x^9 + 1 Fibonacci step; zero seeds are forced to 1 so the LFSR never locks up
    always_comb begin
        lfsr_next = {lfsr_q[9:0], lfsr_q[10] ^ lfsr_q[8]};
    end

    // Mask is the latched key and its complement tiled across the word; the add drops carry out of bit 60
    always_comb begin
        mask_b   = {r_q[4:0], ~r_q, r_q, ~r_q, ~r_q, r_q};
        masked_y = {p_q, 1'b0} + {1'b0, mask_b};
    end

    // Words are only accepted when idle and not being reseeded in the same cycle
    always_comb begin
        in_ready = (state_q == IDLE) && !seed_load;
    end

    // Next-state and datapath: accept -> compute frame -> hold until downstream takes it
    always_comb begin
        state_d     = state_q;
        lfsr_d      = lfsr_q;
        p_d         = p_q;
        r_d         = r_q;
        out_valid_d = out_valid_q;
        out_enc_d   = out_enc_q;
        enc_count_d = enc_count_q;
        case (state_q)
            IDLE: begin
                if (seed_load) begin
                    lfsr_d = (seed == 11'd0) ? 11'h001 : seed;
                end else if (in_valid) begin
                    p_d     = data_in;
                    r_d     = lfsr_q;
                    lfsr_d  = lfsr_next;
                    state_d = CALC;
                end
            end
            CALC: begin
                out_enc_d   = {r_q, masked_y, FUNC_ID};
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    enc_count_d = enc_count_q + 16'd1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset drops any word in flight without emitting it
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= IDLE;
            lfsr_q      <= LFSR_SEED;
            p_q         <= 60'd0;
            r_q         <= 11'd0;
            out_valid_q <= 1'b0;
            out_enc_q   <= 78'd0;
            enc_count_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            p_q         <= p_d;
            r_q         <= r_d;
            out_valid_q <= out_valid_d;
            out_enc_q   <= out_enc_d;
            enc_count_q <= enc_count_d;
        end
    end

    assign out_valid = out_valid_q;
    assign outEnc    = out_enc_q;
    assign enc_count = enc_count_q;

endmodule

// File: tb/tb_encrypt_function_4.sv
// tb/tb_encrypt_function_4.sv - directed and round-trip checks for encrypt_function_4
module tb_encrypt_function_4;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        seed_load = 1'b0;
    logic [10:0] seed = 11'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [59:0] data_in = 60'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [77:0] outEnc;
    logic [15:0] enc_count;

    int total = 0;
    int bad = 0;

    encrypt_function_4 dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .seed_load (seed_load),
        .seed      (seed),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .outEnc    (outEnc),
        .enc_count (enc_count)
    );

    always #5 Clk = ~Clk;

    function automatic logic [10:0] model_lfsr(input logic [10:0] v);
        return {v[9:0], v[10] ^ v[8]};
    endfunction

    function automatic logic [60:0] model_b(input logic [10:0] r);
        logic [60:0] b;
        b = 61'd0;
        for (int i = 0; i < 60; i++) begin
            if (i < 11)      b[i] = r[i];
            else if (i < 22) b[i] = ~r[i - 11];
            else if (i < 33) b[i] = ~r[i - 22];
            else if (i < 44) b[i] = r[i - 33];
            else if (i < 55) b[i] = ~r[i - 44];
            else             b[i] = r[i - 55];
        end
        return b;
    endfunction

    function automatic logic [77:0] model_frame(input logic [10:0] r, input logic [59:0] p);
        logic [60:0] y;
        y = {p, 1'b0} + model_b(r);
        return {r, y, 6'd4};
    endfunction

    function automatic logic [59:0] model_decrypt(input logic [77:0] f);
        logic [60:0] y;
        y = f[66:6] - model_b(f[77:67]);
        return y[60:1];
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [77:0] obs, input logic [77:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic load_seed(input logic [10:0] s);
        seed_load = 1'b1;
        seed = s;
        #1;
        check("seed_blocks_ready", {77'd0, in_ready}, 78'd0);
        tick();
        seed_load = 1'b0;
        #1;
    endtask

    task automatic send(input logic [59:0] w);
        int n;
        n = 0;
        in_valid = 1'b1;
        data_in = w;
        #1;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        check("accept_timeout", {77'd0, (n < 50)}, 78'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_out();
        int n;
        n = 0;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
        check("out_valid_timeout", {77'd0, (n < 50)}, 78'd1);
    endtask

    task automatic take();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    logic [77:0] exp_f;
    logic [77:0] held;
    logic [10:0] key_m;
    logic [63:0] rnd;
    logic [59:0] word;

    initial begin
        // reset state
        tick();
        tick();
        Reset = 1'b0;
        #1;
        check("rst_out_valid", {77'd0, out_valid}, 78'd0);
        check("rst_outEnc", outEnc, 78'd0);
        check("rst_enc_count", {62'd0, enc_count}, 78'd0);
        check("rst_in_ready", {77'd0, in_ready}, 78'd1);

        // zero word with key 7FF, latency and count
        load_seed(11'h7FF);
        send(60'd0);
        check("lat_calc_valid", {77'd0, out_valid}, 78'd0);
        check("lat_calc_ready", {77'd0, in_ready}, 78'd0);
        tick();
        check("lat_done_valid", {77'd0, out_valid}, 78'd1);
        check("zero_frame", outEnc, {11'h7FF, 61'h0F80_0FFE_0000_07FF, 6'd4});
        check("zero_cnt_before", {62'd0, enc_count}, 78'd0);
        take();
        check("zero_valid_after", {77'd0, out_valid}, 78'd0);
        check("zero_cnt_after", {62'd0, enc_count}, 78'd1);
        check("zero_enc_held", outEnc, {11'h7FF, 61'h0F80_0FFE_0000_07FF, 6'd4});

        // carry out of bit 60 dropped, then LFSR step to 7FE
        load_seed(11'h7FF);
        send(60'hFFF_FFFF_FFFF_FFFF);
        wait_out();
        check("carry_y", {17'd0, outEnc[66:6]}, {17'd0, 61'h0F80_0FFE_0000_07FD});
        check("carry_key", {67'd0, outEnc[77:67]}, {67'd0, 11'h7FF});
        take();
        send(60'h123_4567_89AB_CDEF);
        wait_out();
        check("second_key", {67'd0, outEnc[77:67]}, {67'd0, 11'h7FE});
        check("second_decrypt", {18'd0, model_decrypt(outEnc)}, {18'd0, 60'h123_4567_89AB_CDEF});
        take();

        // zero seed is replaced by 1
        load_seed(11'h000);
        send(60'd0);
        wait_out();
        check("seed0_frame", outEnc, {11'h001, 61'h00FF_E003_FFBF_F001, 6'd4});
        take();

        // backpressure in DONE: frame holds, inputs ignored, LFSR untouched
        send(60'hABC_DEF0_1234_5678);
        wait_out();
        exp_f = model_frame(11'h002, 60'hABC_DEF0_1234_5678);
        check("bp_frame", outEnc, exp_f);
        held = outEnc;
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            seed_load = i[1];
            seed = 11'h3C3;
            data_in = 60'hFFF_0000_FFFF_0000;
            tick();
            check("bp_hold_enc", outEnc, held);
            check("bp_hold_valid", {77'd0, out_valid}, 78'd1);
            check("bp_in_ready", {77'd0, in_ready}, 78'd0);
        end
        in_valid = 1'b0;
        seed_load = 1'b0;
        check("bp_cnt_before", {62'd0, enc_count}, 78'd4);
        take();
        check("bp_release_valid", {77'd0, out_valid}, 78'd0);
        check("bp_cnt_after", {62'd0, enc_count}, 78'd5);
        tick();
        tick();
        check("bp_single_hs", {62'd0, enc_count}, 78'd5);
        send(60'd7);
        wait_out();
        check("bp_lfsr_kept", {67'd0, outEnc[77:67]}, {67'd0, 11'h004});
        take();

        // reset while in CALC
        send(60'h555_5555_5555_5555);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check("midrst_valid", {77'd0, out_valid}, 78'd0);
        check("midrst_enc", outEnc, 78'd0);
        check("midrst_cnt", {62'd0, enc_count}, 78'd0);
        check("midrst_ready", {77'd0, in_ready}, 78'd1);
        tick();
        tick();
        check("midrst_no_frame", {77'd0, out_valid}, 78'd0);
        send(60'd1);
        wait_out();
        check("midrst_key", {67'd0, outEnc[77:67]}, {67'd0, 11'h5A5});

        // round trip of random words from a fresh reset
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        key_m = 11'h5A5;
        for (int i = 0; i < 1000; i++) begin
            rnd = {$urandom(), $urandom()};
            word = rnd[59:0];
            send(word);
            wait_out();
            check("rt_key", {67'd0, outEnc[77:67]}, {67'd0, key_m});
            check("rt_plain", {18'd0, model_decrypt(outEnc)}, {18'd0, word});
            take();
            key_m = model_lfsr(key_m);
        end
        check("rt_count", {62'd0, enc_count}, {62'd0, 16'd1000});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
